fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, drives the instruction-memory request, and presents the fetched word, PC+4, the IF/ID enable and the IF/ID flush to the IF/ID latch. It also handles branch/jump redirects from later stages, hazard stalls and halt, and never changes the instruction address while an instruction-cache request is outstanding.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction cache returns valid `imemload` for `imemaddr` this cycle.
- imemload  in  32  instruction word from the cache.
- stall  in  1  hazard unit: hold PC, do not advance IF/ID.
- redirect  in  1  single-cycle pulse: taken branch, jump or jr resolved downstream.
- redirect_pc  in  32  redirect target.
- halt  in  1  halt instruction has reached the commit point.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction address, equal to the fetch address register.
- instr  out  32  equal to `imemload`.
- pcp4  out  32  fetch address + 4.
- fetch_valid  out  1  IF/ID enable: capture `instr` and `pcp4` this edge.
- flush_ifid  out  1  IF/ID flush.

## Operation
- **State:**
  - `pc` is a 32-bit register.
  - `pend_pc` is a 32-bit register.
  - The state machine has three states: FETCH, REDIR_PEND, HALTED.
- **Address rule:** `redirect_pc[1:0]` is forced to 2'b00 when used.
- **pcp4** is `pc + 4`, computed modulo 2^32. 32'hFFFF_FFFC gives 32'h0000_0000.
- **imemREN** is 1 in FETCH and REDIR_PEND, 0 in HALTED, and 0 while nRST is low.
- **Address stability:** `imemaddr` must not change between the first cycle `imemREN` is 1 for an address and the cycle `ihit` is 1. `pc` therefore updates only on an `ihit` edge.
- **FETCH:** evaluated in priority order.
  1. `halt` → HALTED. `pc` is held.
  2. `redirect` && `ihit` → `pc` <= aligned `redirect_pc`. Stay in FETCH. `stall` is ignored.
  3. `redirect` && !`ihit` → `pend_pc` <= aligned `redirect_pc`. Go to REDIR_PEND. `pc` is held.
  4. `ihit` && !`stall` → `pc` <= `pc + 4`.
  5. Otherwise `pc` is held.
- **REDIR_PEND:**
  - `halt` → HALTED.
  - A new `redirect` overwrites `pend_pc`; the latest target wins.
  - On `ihit`, the returned word is discarded: `pc` <= `pend_pc` (or the new target if `redirect` is also 1), then go to FETCH.
  - `stall` has no effect on leaving this state.
- **HALTED:** absorbing state until reset. `pc` is frozen, `imemREN`=0, and `fetch_valid`=0.
- **fetch_valid** = (state==FETCH) && `ihit` && !`stall` && !`redirect` && !`halt`.
- **flush_ifid** = `redirect` || (state==REDIR_PEND). It is combinational and does not depend on `ihit` or `stall`.

## Timing
- **Reset values** (while nRST is low):
  - `pc`=PC_INIT, `pend_pc`=0, state=FETCH.
  - `imemaddr`=PC_INIT, `pcp4`=PC_INIT+4.
  - `imemREN`=0, `fetch_valid`=0, `flush_ifid`=0.
  - `instr` follows `imemload`.
- After nRST rises, `imemREN`=1 on the first cycle.
- **Combinational outputs:** every output is combinational from the registers and the current inputs. No output is registered.
- **Latency:**
  - An `ihit` at edge N makes the next address visible on `imemaddr` after edge N.
  - A back-to-back hit stream advances one word per cycle.
- **Redirect with `ihit` in the same cycle:** the target appears on `imemaddr` the next cycle, and IF/ID is flushed at that same edge.
- **Redirect during a cache miss:**
  - `flush_ifid` stays 1 from the redirect cycle through the cycle of the discarding `ihit`.
  - The target is issued the cycle after that hit.
- **Reset mid-operation:** asynchronous. A pending redirect is lost and state returns to FETCH at PC_INIT.
- **Simultaneous events:**
  - `halt` beats `redirect`, which beats `stall`.
  - `halt` in REDIR_PEND drops `pend_pc`.

## Test plan
- **Sequential fetch:** reset with PC_INIT=0, `ihit`=1 for 4 cycles, `stall`=0 → `imemaddr` = 0, 4, 8, 12; `fetch_valid`=1 in each cycle; `pcp4` = 4, 8, 12, 16.
- **Stall:** at `pc`=0x10 with `ihit`=1 and `stall`=1 for 3 cycles → `imemaddr` holds 0x10 and `fetch_valid`=0. After `stall` drops, the next edge gives 0x14.
- **Redirect on a hit:** at `pc`=0x20, `redirect`=1 with `redirect_pc`=0x103 and `ihit`=1 → `flush_ifid`=1 and `fetch_valid`=0 that cycle; next `imemaddr`=0x100.
- **Redirect during a miss:** at `pc`=0x40 with `ihit`=0, `redirect` to 0x200, then `ihit` arrives 3 cycles later →
  - `imemaddr` stays 0x40 throughout the miss.
  - `flush_ifid`=1 for all 4 cycles.
  - `fetch_valid`=0.
  - `imemaddr`=0x200 after the hit.
  - Repeat with a second redirect to 0x300 during the miss → next address is 0x300.
- **Halt:** `halt`=1 at `pc`=0x80 (also with `redirect`=1 in the same cycle) → HALTED, `imemREN`=0, `imemaddr` stays 0x80 for 10 cycles, and `fetch_valid`=0. Pulsing nRST low → `imemaddr`=0 and `imemREN` resumes.
- **Wrap-around:** PC_INIT=32'hFFFF_FFFC with `ihit`=1 → `pcp4`=0, and the next `imemaddr`=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-cache request/response plus the pipeline
// control inputs and the IF/ID-facing outputs of the fetch unit.
interface fetch_unit_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr;
  logic [31:0] pcp4;
  logic        fetch_valid;
  logic        flush_ifid;

  modport master (
    input  ihit, imemload, stall, redirect, redirect_pc, halt,
    output imemREN, imemaddr, instr, pcp4, fetch_valid, flush_ifid
  );

  modport slave (
    output ihit, imemload, stall, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, instr, pcp4, fetch_valid, flush_ifid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-cache reads and
// handles redirects, stalls and halt without moving the address mid-request.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         nRST,
  fetch_unit_if.master fif
);

  typedef enum logic [1:0] {FETCH, REDIR_PEND, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] target;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state   <= FETCH;
      pc      <= PC_INIT;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_pc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    target    = fif.redirect_pc & 32'hFFFF_FFFC;
    case (state)
      FETCH: begin
        if (fif.halt) begin
          state_n = HALTED;
        end else if (fif.redirect && fif.ihit) begin
          pc_n = target;
        end else if (fif.redirect) begin
          // Cache request still outstanding: park the target until it returns.
          pend_pc_n = target;
          state_n   = REDIR_PEND;
        end else if (fif.ihit && !fif.stall) begin
          pc_n = pc + 32'd4;
        end
      end
      REDIR_PEND: begin
        if (fif.halt) begin
          state_n   = HALTED;
          pend_pc_n = '0;
        end else if (fif.ihit) begin
          pc_n    = fif.redirect ? target : pend_pc;
          state_n = FETCH;
        end else if (fif.redirect) begin
          pend_pc_n = target;
        end
      end
      HALTED:  state_n = HALTED;
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    fif.imemREN     = nRST && (state != HALTED);
    fif.imemaddr    = pc;
    fif.pcp4        = pc + 32'd4;
    fif.instr       = fif.imemload;
    fif.fetch_valid = nRST && (state == FETCH) && fif.ihit && !fif.stall
                      && !fif.redirect && !fif.halt;
    fif.flush_ifid  = nRST && (fif.redirect || (state == REDIR_PEND));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a flag-based reference model.
module tb_fetch_unit;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  fetch_unit_if fif ();
  fetch_unit_if wif ();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (.CLK(CLK), .nRST(nRST), .fif(fif));
  fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (.CLK(CLK), .nRST(nRST), .fif(wif));

  int checks = 0;
  int errors = 0;

  // Reference model: PC, whether a redirect is waiting for its miss to
  // resolve, the latest waiting target, and whether the unit has halted.
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_pending;
  bit          m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("imemREN", {31'd0, fif.imemREN}, {31'd0, !m_halted});
    chk("imemaddr", fif.imemaddr, m_pc);
    chk("pcp4", fif.pcp4, m_pc + 32'd4);
    chk("instr", fif.instr, fif.imemload);
    chk("fetch_valid", {31'd0, fif.fetch_valid},
        {31'd0, !m_halted && !m_pending && fif.ihit && !fif.stall && !fif.redirect && !fif.halt});
    chk("flush_ifid", {31'd0, fif.flush_ifid}, {31'd0, fif.redirect || m_pending});
  endtask

  task automatic model_edge(input bit hi, input bit st, input bit rd,
                            input logic [31:0] rpc, input bit hl);
    logic [31:0] aligned;
    aligned = {rpc[31:2], 2'b00};
    if (m_halted) return;
    if (hl) begin
      m_halted  = 1;
      m_pending = 0;
    end else if (m_pending) begin
      if (rd) m_target = aligned;
      if (hi) begin
        m_pc      = m_target;
        m_pending = 0;
      end
    end else if (rd) begin
      if (hi) m_pc = aligned;
      else begin
        m_pending = 1;
        m_target  = aligned;
      end
    end else if (hi && !st) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cyc(input bit hi, input bit st, input bit rd,
                     input logic [31:0] rpc, input bit hl);
    fif.ihit        = hi;
    fif.stall       = st;
    fif.redirect    = rd;
    fif.redirect_pc = rpc;
    fif.halt        = hl;
    fif.imemload    = $urandom;
    #1;
    check_outputs();
    @(posedge CLK);
    model_edge(hi, st, rd, rpc, hl);
    #1;
  endtask

  task automatic do_reset();
    fif.ihit = 1'b1; fif.redirect = 1'b1; fif.stall = 1'b0; fif.halt = 1'b0;
    fif.redirect_pc = 32'h0000_0ABC;
    fif.imemload = $urandom;
    wif.ihit = 1'b0;
    nRST = 1'b0;
    #1;
    chk("rst_imemREN", {31'd0, fif.imemREN}, 32'd0);
    chk("rst_imemaddr", fif.imemaddr, 32'h0);
    chk("rst_pcp4", fif.pcp4, 32'h4);
    chk("rst_fetch_valid", {31'd0, fif.fetch_valid}, 32'd0);
    chk("rst_flush_ifid", {31'd0, fif.flush_ifid}, 32'd0);
    chk("rst_instr", fif.instr, fif.imemload);
    m_pc = 32'h0; m_target = 32'h0; m_pending = 0; m_halted = 0;
    fif.ihit = 1'b0; fif.redirect = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    fif.ihit = 1'b0; fif.stall = 1'b0; fif.redirect = 1'b0; fif.halt = 1'b0;
    fif.redirect_pc = '0; fif.imemload = '0;
    wif.ihit = 1'b0; wif.stall = 1'b0; wif.redirect = 1'b0; wif.halt = 1'b0;
    wif.redirect_pc = '0; wif.imemload = 32'h1234_5678;
    #2;
    do_reset();

    // Wrap-around on the second instance while the main one starts fetching.
    chk("wrap_addr", wif.imemaddr, 32'hFFFF_FFFC);
    chk("wrap_pcp4", wif.pcp4, 32'h0);
    wif.ihit = 1'b1;

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (i == 0) begin
        chk("wrap_next_addr", wif.imemaddr, 32'h0);
        wif.ihit = 1'b0;
      end
    end
    chk("seq_addr", fif.imemaddr, 32'h10);

    // Stall holds the address
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    chk("stall_hold", fif.imemaddr, 32'h10);
    cyc(1, 0, 0, 0, 0);
    chk("stall_resume", fif.imemaddr, 32'h14);

    // Redirect on a hit with misaligned target
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_redir", fif.imemaddr, 32'h20);
    cyc(1, 0, 1, 32'h103, 0);
    chk("redir_hit", fif.imemaddr, 32'h100);

    // Redirect during a miss
    cyc(1, 0, 1, 32'h40, 0);
    cyc(0, 0, 1, 32'h200, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("miss_redir", fif.imemaddr, 32'h200);

    // Second redirect during the miss wins
    cyc(1, 0, 1, 32'h40, 0);
    cyc(0, 0, 1, 32'h200, 0);
    cyc(0, 0, 1, 32'h300, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("miss_redir2", fif.imemaddr, 32'h300);

    // Halt beats a simultaneous redirect
    cyc(1, 0, 1, 32'h80, 0);
    cyc(1, 0, 1, 32'h500, 1);
    for (int i = 0; i < 10; i++)
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, $urandom, 0);
    chk("halt_hold", fif.imemaddr, 32'h80);
    chk("halt_ren", {31'd0, fif.imemREN}, 32'd0);
    do_reset();
    chk("post_halt_addr", fif.imemaddr, 32'h0);
    chk("post_halt_ren", {31'd0, fif.imemREN}, 32'd1);

    // Randomized traffic, including halts and mid-run resets
    for (int i = 0; i < 600; i++) begin
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0)
        do_reset();
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 2, $urandom, $urandom_range(0, 79) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
